// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         CNT_W_DEFAULT = 16;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between ID/EX and IF/ID.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_rd_addr_i,
    input  logic [4:0] ifid_rs1_addr_i,
    input  logic [4:0] ifid_rs2_addr_i,
    output logic       hazard_o
);

    logic rd_match;

    assign rd_match = (idex_rd_addr_i == ifid_rs1_addr_i) | (idex_rd_addr_i == ifid_rs2_addr_i);
    // x0 is never really written, so a load targeting it cannot create a dependency.
    assign hazard_o = idex_mem_read_i & (idex_rd_addr_i != REG_ZERO) & rd_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: data-memory handshake FSM, load-use bubble,
// branch flush and saturating stall counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RDaddr_i,
    input  logic [4:0]       IFID_RS1addr_i,
    input  logic [4:0]       IFID_RS2addr_i,
    input  logic             EXMEM_MemRead_i,
    input  logic             EXMEM_MemWrite_i,
    input  logic             mem_ack_i,
    input  logic             Branch_i,
    output logic             MemStall_o,
    output logic             mem_req_o,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             NoOp_o,
    output logic             IFID_Flush_o,
    output logic [CNT_W-1:0] mem_stall_cnt_o,
    output logic [CNT_W-1:0] hazard_cnt_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] mem_stall_cnt_q, mem_stall_cnt_d;
    logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;
    logic             memop;
    logic             hazard;
    logic             stall;
    logic             req;

    assign memop = EXMEM_MemRead_i | EXMEM_MemWrite_i;

    hazard_detect u_hazard_detect (
        .idex_mem_read_i (IDEX_MemRead_i),
        .idex_rd_addr_i  (IDEX_RDaddr_i),
        .ifid_rs1_addr_i (IFID_RS1addr_i),
        .ifid_rs2_addr_i (IFID_RS2addr_i),
        .hazard_o        (hazard)
    );

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    stall   = 1'b1;
                    req     = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                req   = 1'b1;
                if (mem_ack_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset must kill the request at once, even when IDLE sees a pending memop.
    assign MemStall_o   = stall & ~rst_i;
    assign mem_req_o    = req & ~rst_i;
    assign NoOp_o       = hazard & ~MemStall_o;
    assign PCWrite_o    = ~NoOp_o;
    assign IFID_Write_o = ~NoOp_o;
    assign IFID_Flush_o = Branch_i & ~MemStall_o;

    always_comb begin
        mem_stall_cnt_d = mem_stall_cnt_q;
        hazard_cnt_d    = hazard_cnt_q;
        if (MemStall_o && (mem_stall_cnt_q != {CNT_W{1'b1}})) begin
            mem_stall_cnt_d = mem_stall_cnt_q + CNT_W'(1);
        end
        if (NoOp_o && (hazard_cnt_q != {CNT_W{1'b1}})) begin
            hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            mem_stall_cnt_q <= '0;
            hazard_cnt_q    <= '0;
        end else begin
            state_q         <= state_d;
            mem_stall_cnt_q <= mem_stall_cnt_d;
            hazard_cnt_q    <= hazard_cnt_d;
        end
    end

    assign mem_stall_cnt_o = mem_stall_cnt_q;
    assign hazard_cnt_o    = hazard_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl against a behavioural handshake model.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       idex_mr;
    logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
    logic       exmem_mr, exmem_mw, ack, branch;

    logic        stall_16, req_16, pcw_16, ifw_16, noop_16, flush_16;
    logic        stall_4, req_4, pcw_4, ifw_4, noop_4, flush_4;
    logic [15:0] scnt_16, hcnt_16;
    logic [3:0]  scnt_4, hcnt_4;

    int n_checks = 0;
    int n_errors = 0;

    // Model: "busy" = an access is outstanding; "releasing" = the ack arrived last cycle.
    bit busy, releasing;
    int exp_s16, exp_h16, exp_s4, exp_h4;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .IDEX_MemRead_i(idex_mr), .IDEX_RDaddr_i(idex_rd),
        .IFID_RS1addr_i(ifid_rs1), .IFID_RS2addr_i(ifid_rs2),
        .EXMEM_MemRead_i(exmem_mr), .EXMEM_MemWrite_i(exmem_mw),
        .mem_ack_i(ack), .Branch_i(branch),
        .MemStall_o(stall_16), .mem_req_o(req_16), .PCWrite_o(pcw_16),
        .IFID_Write_o(ifw_16), .NoOp_o(noop_16), .IFID_Flush_o(flush_16),
        .mem_stall_cnt_o(scnt_16), .hazard_cnt_o(hcnt_16)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .IDEX_MemRead_i(idex_mr), .IDEX_RDaddr_i(idex_rd),
        .IFID_RS1addr_i(ifid_rs1), .IFID_RS2addr_i(ifid_rs2),
        .EXMEM_MemRead_i(exmem_mr), .EXMEM_MemWrite_i(exmem_mw),
        .mem_ack_i(ack), .Branch_i(branch),
        .MemStall_o(stall_4), .mem_req_o(req_4), .PCWrite_o(pcw_4),
        .IFID_Write_o(ifw_4), .NoOp_o(noop_4), .IFID_Flush_o(flush_4),
        .mem_stall_cnt_o(scnt_4), .hazard_cnt_o(hcnt_4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_inputs(input bit mr, input bit mw, input bit a, input bit br,
                              input bit lmr, input int rd, input int rs1, input int rs2);
        exmem_mr = mr; exmem_mw = mw; ack = a; branch = br;
        idex_mr = lmr; idex_rd = 5'(rd); ifid_rs1 = 5'(rs1); ifid_rs2 = 5'(rs2);
    endtask

    // Called at posedge+1 with inputs applied: checks combinational outputs,
    // advances the model across the next edge, then checks the counters.
    task automatic step();
        bit memop, exp_stall, hz, bubble, flush;
        #2;
        memop     = exmem_mr | exmem_mw;
        exp_stall = busy || (!releasing && memop);
        hz        = idex_mr && (idex_rd != 0) && ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
        bubble    = hz && !exp_stall;
        flush     = branch && !exp_stall;
        check("MemStall", 32'(stall_16), 32'(exp_stall));
        check("mem_req", 32'(req_16), 32'(exp_stall));
        check("PCWrite", 32'(pcw_16), 32'(!bubble));
        check("IFID_Write", 32'(ifw_16), 32'(!bubble));
        check("NoOp", 32'(noop_16), 32'(bubble));
        check("IFID_Flush", 32'(flush_16), 32'(flush));
        check("MemStall_w4", 32'(stall_4), 32'(exp_stall));
        if (releasing) begin
            releasing = 0;
            busy = 0;
        end else if (exp_stall) begin
            if (busy && ack) begin
                busy = 0;
                releasing = 1;
            end else begin
                busy = 1;
            end
        end
        if (exp_stall) begin
            exp_s16 = (exp_s16 < 65535) ? exp_s16 + 1 : 65535;
            exp_s4  = (exp_s4 < 15) ? exp_s4 + 1 : 15;
        end
        if (bubble) begin
            exp_h16 = (exp_h16 < 65535) ? exp_h16 + 1 : 65535;
            exp_h4  = (exp_h4 < 15) ? exp_h4 + 1 : 15;
        end
        @(posedge clk);
        #1;
        check("stall_cnt", 32'(scnt_16), 32'(exp_s16));
        check("hazard_cnt", 32'(hcnt_16), 32'(exp_h16));
        check("stall_cnt_w4", 32'(scnt_4), 32'(exp_s4));
        check("hazard_cnt_w4", 32'(hcnt_4), 32'(exp_h4));
    endtask

    // Asynchronous reset applied mid-cycle; effects checked before any edge.
    task automatic do_reset();
        #1;
        rst = 1'b1;
        #1;
        check("rst_mem_req", 32'(req_16), 32'd0);
        check("rst_stall", 32'(stall_16), 32'd0);
        check("rst_stall_cnt", 32'(scnt_16), 32'd0);
        check("rst_hazard_cnt", 32'(hcnt_16), 32'd0);
        busy = 0; releasing = 0;
        exp_s16 = 0; exp_h16 = 0; exp_s4 = 0; exp_h4 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        busy = 0; releasing = 0;
        exp_s16 = 0; exp_h16 = 0; exp_s4 = 0; exp_h4 = 0;
        @(posedge clk);
        #1;
        check("reset_PCWrite", 32'(pcw_16), 32'd1);
        check("reset_IFID_Write", 32'(ifw_16), 32'd1);
        check("reset_NoOp", 32'(noop_16), 32'd0);
        check("reset_Flush", 32'(flush_16), 32'd0);
        check("reset_stall_cnt", 32'(scnt_16), 32'd0);
        rst = 1'b0;

        // Load in EX/MEM, ack after three REQ cycles: four stalled cycles, then DONE.
        for (int i = 0; i < 4; i++) begin
            set_inputs(1, 0, (i == 3), 0, 0, 0, 0, 0);
            step();
        end
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("done_stall_low", 32'(stall_16), 32'd0);
        step();
        check("four_cycle_stall_cnt", 32'(scnt_16), 32'd4);

        // Load-use on rs2=x5: exactly one bubble.
        set_inputs(0, 0, 0, 0, 1, 5, 7, 5);
        #2;
        check("loaduse_noop", 32'(noop_16), 32'd1);
        check("loaduse_pcwrite", 32'(pcw_16), 32'd0);
        step();
        set_inputs(0, 0, 0, 0, 0, 5, 7, 5);
        step();
        check("loaduse_hazard_cnt", 32'(hcnt_16), 32'd1);

        // Load to x0 never stalls.
        set_inputs(0, 0, 0, 0, 1, 0, 0, 3);
        #2;
        check("x0_no_bubble", 32'(noop_16), 32'd0);
        step();

        // Branch held during a store stall flushes only in the DONE cycle.
        for (int i = 0; i < 3; i++) begin
            set_inputs(0, 1, (i == 2), 1, 0, 0, 0, 0);
            step();
        end
        set_inputs(0, 0, 0, 1, 0, 0, 0, 0);
        #2;
        check("branch_flush_on_release", 32'(flush_16), 32'd1);
        step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_inputs(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                       $urandom_range(0, 1), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            step();
        end

        // Reset in the middle of REQ with the memop still present.
        set_inputs(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        set_inputs(1, 0, 1, 0, 0, 0, 0, 0);
        do_reset();

        // Long stall saturates the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            set_inputs(1, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        check("sat_stall_cnt_w4", 32'(scnt_4), 32'd15);
        check("nosat_stall_cnt_w16", 32'(scnt_16), 32'd20);
        set_inputs(1, 0, 1, 0, 0, 0, 0, 0);
        step();
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
